// File: rtl/axi_pkg.sv
// Shared bus constants for the write-response path: response codes and the
// default ID width used by subordinates.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ID_W_DEFAULT = 4;

endpackage

// File: rtl/wresp_queue_subo.sv
// In-order write-response queue: records write IDs as they are accepted,
// marks them finished as write data completes, and returns B responses in order.
module wresp_queue_subo
  import axi_pkg::*;
#(
  parameter  int ID_W  = ID_W_DEFAULT,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqc_s_valid,
  input  logic [ID_W-1:0]  reqc_s_id,
  output logic             reqc_s_ready,
  input  logic             finish_swd,
  input  logic             finish_err,
  output logic             bvalid,
  input  logic             bready,
  output logic [ID_W-1:0]  bid,
  output logic [1:0]       bresp,
  output logic             bcomp,
  output logic [PTR_W:0]   outstanding,
  output logic             proto_err
);

  logic [ID_W-1:0]  id_reg [DEPTH];
  logic [DEPTH-1:0] done_reg;
  logic [DEPTH-1:0] err_reg;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] fin_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   pend_reg;
  logic             proto_err_reg;

  logic push;
  logic fin_acc;
  logic pop;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign reqc_s_ready = (count_reg != (PTR_W+1)'(DEPTH));
  assign push         = reqc_s_valid & reqc_s_ready;
  assign fin_acc      = finish_swd & (pend_reg != '0);
  assign pop          = bvalid & bready;

  assign bvalid      = (count_reg != '0) & done_reg[rd_ptr_reg];
  assign bid         = id_reg[rd_ptr_reg];
  assign bresp       = err_reg[rd_ptr_reg] ? RESP_SLVERR : RESP_OKAY;
  assign bcomp       = 1'b1;
  assign outstanding = count_reg;
  assign proto_err   = proto_err_reg;

  // The three pointers can never address the same slot with an active
  // operation in one cycle, so the per-entry priority below never drops one.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          id_reg[gi]   <= '0;
          done_reg[gi] <= 1'b0;
          err_reg[gi]  <= 1'b0;
        end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
          id_reg[gi]   <= reqc_s_id;
          done_reg[gi] <= 1'b0;
          err_reg[gi]  <= 1'b0;
        end else if (fin_acc && fin_ptr_reg == PTR_W'(gi)) begin
          done_reg[gi] <= 1'b1;
          err_reg[gi]  <= finish_err;
        end else if (pop && rd_ptr_reg == PTR_W'(gi)) begin
          done_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      fin_ptr_reg   <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      pend_reg      <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (push)    wr_ptr_reg  <= wr_ptr_reg + 1'b1;
      if (fin_acc) fin_ptr_reg <= fin_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      pend_reg  <= pend_reg + (PTR_W+1)'(push) - (PTR_W+1)'(fin_acc);
      if ((reqc_s_valid && !reqc_s_ready) || (finish_swd && pend_reg == '0))
        proto_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wresp_queue_subo.sv
// Bench for wresp_queue_subo: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_wresp_queue_subo;

  localparam int ID_W  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reqc_s_valid = 1'b0;
  logic [ID_W-1:0] reqc_s_id = '0;
  logic            reqc_s_ready;
  logic            finish_swd = 1'b0;
  logic            finish_err = 1'b0;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bcomp;
  logic [2:0]      outstanding;
  logic            proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wresp_queue_subo #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .reqc_s_valid(reqc_s_valid), .reqc_s_id(reqc_s_id), .reqc_s_ready(reqc_s_ready),
    .finish_swd(finish_swd), .finish_err(finish_err),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .bcomp(bcomp),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            done;
    logic            err;
  } ent_t;

  ent_t q[$];
  bit   m_perr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of outstanding writes in request order; unfinished ones are the tail.
  task automatic model_step(input bit r, input bit v, input logic [ID_W-1:0] id,
                            input bit f, input bit e, input bit br);
    int   sz;
    int   pend;
    bit   pop_now;
    ent_t t;
    if (r) begin
      q.delete();
      m_perr = 1'b0;
      return;
    end
    sz = q.size();
    pend = 0;
    foreach (q[k]) if (!q[k].done) pend++;
    pop_now = (sz > 0) && q[0].done && br;
    if (f) begin
      if (pend > 0) begin
        t = q[sz - pend];
        t.done = 1'b1;
        t.err  = e;
        q[sz - pend] = t;
      end else begin
        m_perr = 1'b1;
      end
    end
    if (pop_now) void'(q.pop_front());
    if (v) begin
      if (sz < DEPTH) q.push_back('{id: id, done: 1'b0, err: 1'b0});
      else m_perr = 1'b1;
    end
  endtask

  task automatic compare_all();
    bit exp_bv;
    exp_bv = (q.size() > 0) && q[0].done;
    chk("bvalid", int'(bvalid), int'(exp_bv));
    chk("ready", int'(reqc_s_ready), int'(q.size() != DEPTH));
    chk("outstanding", int'(outstanding), q.size());
    chk("proto_err", int'(proto_err), int'(m_perr));
    chk("bcomp", int'(bcomp), 1);
    if (exp_bv) begin
      chk("bid", int'(bid), int'(q[0].id));
      chk("bresp", int'(bresp), q[0].err ? 2 : 0);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare at negedge.
  task automatic step(input bit r, input bit v, input logic [ID_W-1:0] id,
                      input bit f, input bit e, input bit br);
    rst = r; reqc_s_valid = v; reqc_s_id = id;
    finish_swd = f; finish_err = e; bready = br;
    @(posedge clk);
    model_step(r, v, id, f, e, br);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit br);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, br);
  endtask

  task automatic push(input logic [ID_W-1:0] id);
    step(1'b0, 1'b1, id, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit errs [4];
    errs = '{1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_bvalid", int'(bvalid), 0);
    chk("rst_bid", int'(bid), 0);
    chk("rst_bresp", int'(bresp), 0);
    chk("rst_ready", int'(reqc_s_ready), 1);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_proto_err", int'(proto_err), 0);

    // Single write
    push(4'd3);
    idle(1'b0);
    chk("single_pre_bvalid", int'(bvalid), 0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("single_bvalid", int'(bvalid), 1);
    chk("single_bid", int'(bid), 3);
    chk("single_bresp", int'(bresp), 0);
    idle(1'b1);
    chk("single_drained", int'(outstanding), 0);

    // Fill to depth, overflow push, then in-order drain
    for (int i = 1; i <= 4; i++) push(ID_W'(i));
    chk("fill_ready", int'(reqc_s_ready), 0);
    chk("fill_count", int'(outstanding), 4);
    push(4'd5);
    chk("overflow_perr", int'(proto_err), 1);
    chk("overflow_count", int'(outstanding), 4);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, 1'b1, errs[k], 1'b1);
      chk("fill_bid", int'(bid), k + 1);
      chk("fill_bresp", int'(bresp), errs[k] ? 2 : 0);
    end
    idle(1'b1);
    chk("fill_drained", int'(outstanding), 0);
    do_reset();

    // Backpressure holds the response
    push(4'd7);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      chk("bp_bvalid", int'(bvalid), 1);
      chk("bp_bid", int'(bid), 7);
    end
    idle(1'b1);
    chk("bp_pop", int'(outstanding), 0);
    chk("bp_bvalid_after", int'(bvalid), 0);

    // Push, finish and pop in one cycle
    push(4'd10);
    push(4'd11);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1);
    chk("simul_count", int'(outstanding), 2);
    chk("simul_bid", int'(bid), 11);
    chk("simul_bresp", int'(bresp), 2);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("simul_bid2", int'(bid), 9);
    idle(1'b1);
    chk("simul_drained", int'(outstanding), 0);

    // Spurious finish
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("spur_bvalid", int'(bvalid), 0);
    chk("spur_perr", int'(proto_err), 1);
    do_reset();

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(ID_W'(i));
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("wrap_bid", int'(bid), i);
      idle(1'b1);
    end

    // Reset mid-operation
    push(4'd1);
    push(4'd2);
    push(4'd3);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("mid_bvalid", int'(bvalid), 1);
    push(4'd4);
    push(4'd5);
    chk("mid_perr", int'(proto_err), 1);
    do_reset();
    chk("mid_rst_bvalid", int'(bvalid), 0);
    chk("mid_rst_count", int'(outstanding), 0);
    chk("mid_rst_ready", int'(reqc_s_ready), 1);
    chk("mid_rst_perr", int'(proto_err), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 45,
           ID_W'($urandom),
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
